// File: rtl/alarm_pkg.sv
// ============================================================
// alarm_pkg: state encoding and timer sizing for alarm_zone_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED    = 3'b000,
    EXIT_DELAY  = 3'b001,
    ARMED       = 3'b010,
    ENTRY_DELAY = 3'b011,
    ALARM       = 3'b100
  } alarm_state_t;

  localparam int c_STATE_W = 3;

  // Width needed to hold the largest of the three reload values.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_countdown.sv
// ============================================================
// tick_countdown: loadable down-counter advanced by a tick strobe
// Rev 1.0
// ============================================================
`default_nettype none

module tick_countdown #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  // A load wins over a tick in the same cycle, and zero never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign done  = tick && (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/alarm_zone_ctrl.sv
// ============================================================
// alarm_zone_ctrl: multi-zone intrusion alarm with exit/entry delays
// Rev 1.0
// ============================================================
`default_nettype none

module alarm_zone_ctrl
  import alarm_pkg::*;
#(
  parameter int                 N_ZONES      = 4,
  parameter int                 EXIT_TICKS   = 10,
  parameter int                 ENTRY_TICKS  = 5,
  parameter int                 SIREN_TICKS  = 30,
  parameter logic [N_ZONES-1:0] INSTANT_MASK = N_ZONES'(1),
  localparam int                CNT_W        = cnt_width(EXIT_TICKS, ENTRY_TICKS, SIREN_TICKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [N_ZONES-1:0]   zone_en,
  input  logic [N_ZONES-1:0]   sensor,
  output logic                 alarm,
  output logic [c_STATE_W-1:0] state,
  output logic [CNT_W-1:0]     countdown,
  output logic [N_ZONES-1:0]   latched_zones,
  output logic                 arm_err
);

  localparam logic [CNT_W-1:0] c_EXIT  = CNT_W'(EXIT_TICKS);
  localparam logic [CNT_W-1:0] c_ENTRY = CNT_W'(ENTRY_TICKS);
  localparam logic [CNT_W-1:0] c_SIREN = CNT_W'(SIREN_TICKS);

  alarm_state_t       r_state;
  alarm_state_t       w_next;
  logic [N_ZONES-1:0] r_latched;
  logic [N_ZONES-1:0] w_latched;
  logic [N_ZONES-1:0] w_viol;
  logic [N_ZONES-1:0] w_inst;
  logic               r_arm_err;
  logic               w_arm_err;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic [CNT_W-1:0]   w_count;
  logic               w_done;

  assign w_viol = sensor & zone_en;
  assign w_inst = w_viol & INSTANT_MASK;

  tick_countdown #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .value (w_load_val),
    .tick  (tick),
    .count (w_count),
    .done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DISARMED;
      r_latched <= '0;
      r_arm_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_latched <= w_latched;
      r_arm_err <= w_arm_err;
    end
  end

  // Every state change reloads the timer (value 0 unless a delay starts).
  always_comb begin
    w_next     = r_state;
    w_latched  = r_latched;
    w_arm_err  = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      DISARMED: begin
        if (arm) begin
          if (w_viol == '0) begin
            w_next     = EXIT_DELAY;
            w_load     = 1'b1;
            w_load_val = c_EXIT;
            w_latched  = '0;
          end else begin
            w_arm_err  = 1'b1;
          end
        end
      end
      EXIT_DELAY: begin
        if (disarm) begin
          w_next = DISARMED;
          w_load = 1'b1;
        end else if (w_done) begin
          w_next = ARMED;
          w_load = 1'b1;
        end
      end
      ARMED: begin
        if (disarm) begin
          w_next = DISARMED;
          w_load = 1'b1;
        end else if (w_inst != '0) begin
          w_next     = ALARM;
          w_load     = 1'b1;
          w_load_val = c_SIREN;
          w_latched  = r_latched | w_viol;
        end else if (w_viol != '0) begin
          w_next     = ENTRY_DELAY;
          w_load     = 1'b1;
          w_load_val = c_ENTRY;
          w_latched  = r_latched | w_viol;
        end
      end
      ENTRY_DELAY: begin
        w_latched = r_latched | w_viol;
        if (disarm) begin
          w_next = DISARMED;
          w_load = 1'b1;
        end else if ((w_inst != '0) || w_done) begin
          w_next     = ALARM;
          w_load     = 1'b1;
          w_load_val = c_SIREN;
        end
      end
      ALARM: begin
        w_latched = r_latched | w_viol;
        if (disarm) begin
          w_next = DISARMED;
          w_load = 1'b1;
        end else if (w_done) begin
          w_next = ARMED;
          w_load = 1'b1;
        end
      end
      default: begin
        w_next = DISARMED;
        w_load = 1'b1;
      end
    endcase
  end

  assign alarm         = (r_state == ALARM);
  assign state         = r_state;
  assign countdown     = w_count;
  assign latched_zones = r_latched;
  assign arm_err       = r_arm_err;

endmodule

`default_nettype wire
